commit_ctrl: RTL and testbench

COMMIT_CTRL -- requirements
Module: commit_ctrl

---
 rtl/commit_ctrl.sv | 168 ++++++++++++++++
 tb/tb_commit_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement controller for the ROB head.
// Retires at most one instruction per cycle. ALU results are written to the
// register file in the same cycle the head is popped. A store is held at the
// head until memory reports completion, and it is popped only then. A
// mispredicted branch causes a one-cycle flush, and a halt stops retirement
// until the next reset.
//
// Handshake: mem_req is a valid signal. While mem_req=1 the fields
// mem_addr/mem_data/mem_size stay constant. The request is taken on the first
// cycle where mem_req=1 and mem_gnt=1. mem_done marks write completion. It can
// arrive in the same cycle as mem_gnt, or in a later cycle. Any gnt or done
// that arrives while no request is outstanding has no effect.
module commit_ctrl #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int ZERO_IDX  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic                 head_is_store,
    input  logic                 head_mispredict,
    input  logic                 head_halt,
    input  logic [REG_IDX_W-1:0] head_dest_reg,
    input  logic [XLEN-1:0]      head_value,
    input  logic [XLEN-1:0]      head_addr,
    input  logic [1:0]           head_mem_size,
    output logic                 rob_pop,
    output logic                 rf_wr_en,
    output logic [REG_IDX_W-1:0] rf_wr_idx,
    output logic [XLEN-1:0]      rf_wr_data,
    output logic                 mem_req,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_data,
    output logic [1:0]           mem_size,
    input  logic                 mem_gnt,
    input  logic                 mem_done,
    output logic                 flush,
    output logic                 halted,
    output logic [31:0]          retire_count
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        FLUSH   = 3'd3,
        HALT    = 3'd4
    } state_t;

    // Current and next FSM state. Name this signal when binding checkers.
    state_t state;
    state_t state_next;

    // Store fields captured when a store reaches the head.
    logic [XLEN-1:0] st_addr_q;
    logic [XLEN-1:0] st_data_q;
    logic [1:0]      st_size_q;

    // Combinational decode results, before the reset gating below.
    logic pop_c;
    logic wr_c;
    logic latch_en;
    logic head_go;
    logic dest_nonzero;

    assign head_go      = head_valid && head_ready;
    assign dest_nonzero = (head_dest_reg != REG_IDX_W'(ZERO_IDX));

    // State register. Reset drops any store in flight without popping it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and retire decode. At most one pop is produced per cycle.
    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        wr_c       = 1'b0;
        latch_en   = 1'b0;
        unique case (state)
            RUN: begin
                if (head_go) begin
                    if (head_is_store) begin
                        // Mispredict and halt flags are meaningless for a store.
                        latch_en   = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        pop_c = 1'b1;
                        wr_c  = dest_nonzero;
                        if (head_halt) begin
                            state_next = HALT;
                        end else if (head_mispredict) begin
                            state_next = FLUSH;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (mem_done) begin
                        pop_c      = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    pop_c      = 1'b1;
                    state_next = RUN;
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Capture the store address, data and size as the FSM leaves RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_addr_q <= '0;
            st_data_q <= '0;
            st_size_q <= '0;
        end else if (latch_en) begin
            st_addr_q <= head_addr;
            st_data_q <= head_value;
            st_size_q <= head_mem_size;
        end
    end

    // Count retirements. The counter wraps naturally at 32 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (rob_pop) begin
            retire_count <= retire_count + 32'd1;
        end
    end

    // The RUN decode depends on head inputs, so gate it while reset is low.
    assign rob_pop    = pop_c && reset;
    assign rf_wr_en   = wr_c && reset;
    assign rf_wr_idx  = rf_wr_en ? head_dest_reg : '0;
    assign rf_wr_data = rf_wr_en ? head_value : '0;

    assign mem_req  = (state == ST_REQ);
    assign mem_addr = st_addr_q;
    assign mem_data = st_data_q;
    assign mem_size = st_size_q;

    assign flush  = (state == FLUSH);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl.
// Expected register-file retirements and expected memory requests are queued
// when stimulus is driven. They are popped and compared when the DUT pops the
// ROB head or has a memory request accepted.
module tb_commit_ctrl;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            head_valid, head_ready, head_is_store;
    logic            head_mispredict, head_halt;
    logic [RW-1:0]   head_dest_reg;
    logic [XLEN-1:0] head_value, head_addr;
    logic [1:0]      head_mem_size;
    logic            rob_pop, rf_wr_en, mem_req, mem_gnt, mem_done;
    logic [RW-1:0]   rf_wr_idx;
    logic [XLEN-1:0] rf_wr_data, mem_addr, mem_data;
    logic [1:0]      mem_size;
    logic            flush, halted;
    logic [31:0]     retire_count;

    commit_ctrl #(.XLEN(XLEN), .REG_IDX_W(RW), .ZERO_IDX(0)) dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_ready(head_ready),
        .head_is_store(head_is_store), .head_mispredict(head_mispredict),
        .head_halt(head_halt), .head_dest_reg(head_dest_reg),
        .head_value(head_value), .head_addr(head_addr),
        .head_mem_size(head_mem_size),
        .rob_pop(rob_pop), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_size(mem_size), .mem_gnt(mem_gnt),
        .mem_done(mem_done), .flush(flush), .halted(halted),
        .retire_count(retire_count)
    );

    // Clock generation.
    always #5 clock = ~clock;

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_count = 0;
    logic exp_halted = 1'b0;

    // Retire entry: {wr_en, idx, data}. Store entry: {addr, data, size}.
    logic [37:0] exp_q[$];
    logic [65:0] st_q[$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ret(input logic en, input logic [RW-1:0] idx, input logic [XLEN-1:0] data);
        exp_q.push_back({en, idx, data});
        exp_count++;
    endtask

    task automatic set_head(input logic v, input logic r, input logic st, input logic mp,
                            input logic hl, input logic [RW-1:0] dest,
                            input logic [XLEN-1:0] val, input logic [XLEN-1:0] addr,
                            input logic [1:0] size);
        head_valid = v; head_ready = r; head_is_store = st;
        head_mispredict = mp; head_halt = hl; head_dest_reg = dest;
        head_value = val; head_addr = addr; head_mem_size = size;
    endtask

    task automatic idle_head();
        set_head(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd0);
    endtask

    // One clock: sample on the falling edge, then return 1 time unit after the rising edge.
    task automatic step(input logic exp_pop, input logic exp_req, input logic exp_flush);
        logic [37:0] e;
        logic [65:0] s;
        @(negedge clock);
        chk("rob_pop", 72'(rob_pop), 72'(exp_pop));
        chk("mem_req", 72'(mem_req), 72'(exp_req));
        chk("flush", 72'(flush), 72'(exp_flush));
        chk("halted", 72'(halted), 72'(exp_halted));
        if (rob_pop) begin
            if (exp_q.size() == 0) begin
                chk("sb_retire_underflow", 72'(exp_q.size()), 72'(1));
            end else begin
                e = exp_q.pop_front();
                chk("rf_wr_en", 72'(rf_wr_en), 72'(e[37]));
                if (e[37]) chk("rf_wr_idx_data", 72'({rf_wr_idx, rf_wr_data}), 72'(e[36:0]));
            end
        end else if (rf_wr_en) begin
            chk("wr_without_pop", 72'(rf_wr_en), 72'(0));
        end
        if (mem_req) begin
            if (st_q.size() == 0) begin
                chk("sb_store_underflow", 72'(st_q.size()), 72'(1));
            end else begin
                s = st_q[0];
                chk("mem_fields", 72'({mem_addr, mem_data, mem_size}), 72'(s));
                if (mem_gnt) void'(st_q.pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle_head();
        mem_gnt = 1'b0;
        mem_done = 1'b0;

        // Hold reset while the head looks retirable. Nothing may leak out.
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'hAA, '0, 2'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rob_pop", 72'(rob_pop), 72'(0));
        chk("rst_rf_wr_en", 72'(rf_wr_en), 72'(0));
        chk("rst_mem_req", 72'(mem_req), 72'(0));
        chk("rst_count", 72'(retire_count), 72'(0));
        chk("rst_halted", 72'(halted), 72'(0));
        chk("rst_flush", 72'(flush), 72'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_head();

        // ALU retirement with a register write.
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, '0, 2'd0);
        push_ret(1'b1, 5'd5, 32'h1234);
        step(1'b1, 1'b0, 1'b0);
        idle_head();
        chk("count_after_alu", 72'(retire_count), 72'(exp_count));

        // Zero destination: pop without a write.
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h55, '0, 2'd0);
        push_ret(1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0);
        idle_head();
        chk("count_after_zero", 72'(retire_count), 72'(exp_count));

        // Head not valid or not ready: nothing happens.
        set_head(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22, '0, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        set_head(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22, '0, 2'd0);
        step(1'b0, 1'b0, 1'b0);

        // Store: grant after 2 cycles, done 3 cycles later. The mispredict flag must be ignored.
        set_head(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'hDEADBEEF, 32'h100, 2'd2);
        st_q.push_back({32'h100, 32'hDEADBEEF, 2'd2});
        step(1'b0, 1'b0, 1'b0);
        head_addr = $urandom;
        head_value = $urandom;
        head_mem_size = 2'($urandom_range(0, 3));
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        mem_gnt = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        mem_gnt = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        mem_done = 1'b1;
        push_ret(1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0);
        mem_done = 1'b0;
        idle_head();
        step(1'b0, 1'b0, 1'b0);
        chk("count_after_store", 72'(retire_count), 72'(exp_count));

        // Stray grant and done signals while in RUN are ignored.
        mem_gnt = 1'b1;
        mem_done = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        mem_gnt = 1'b0;
        mem_done = 1'b0;

        // Store with grant and done in the same cycle, then an ALU op right behind it.
        set_head(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'hCAFEF00D, 32'h200, 2'd1);
        st_q.push_back({32'h200, 32'hCAFEF00D, 2'd1});
        step(1'b0, 1'b0, 1'b0);
        mem_gnt = 1'b1;
        mem_done = 1'b1;
        push_ret(1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0);
        mem_gnt = 1'b0;
        mem_done = 1'b0;
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77, '0, 2'd0);
        push_ret(1'b1, 5'd7, 32'h77);
        step(1'b1, 1'b0, 1'b0);
        idle_head();
        chk("count_after_fast_store", 72'(retire_count), 72'(exp_count));

        // Mispredict: retire and write, then a one-cycle flush that blocks a ready head.
        set_head(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h99, '0, 2'd0);
        push_ret(1'b1, 5'd9, 32'h99);
        step(1'b1, 1'b0, 1'b0);
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'hA0, '0, 2'd0);
        step(1'b0, 1'b0, 1'b1);
        push_ret(1'b1, 5'd10, 32'hA0);
        step(1'b1, 1'b0, 1'b0);
        idle_head();
        chk("count_after_flush", 72'(retire_count), 72'(exp_count));

        // Reset while in ST_WAIT, then the store restarts after reset is released.
        set_head(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 32'h3333, 32'h300, 2'd3);
        st_q.push_back({32'h300, 32'h3333, 2'd3});
        step(1'b0, 1'b0, 1'b0);
        mem_gnt = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        mem_gnt = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        mem_done = 1'b1;
        #1;
        chk("wait_rst_mem_req", 72'(mem_req), 72'(0));
        chk("wait_rst_rob_pop", 72'(rob_pop), 72'(0));
        chk("wait_rst_count", 72'(retire_count), 72'(0));
        chk("wait_rst_mem_addr", 72'(mem_addr), 72'(0));
        exp_count = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem_done = 1'b0;
        st_q.push_back({32'h300, 32'h3333, 2'd3});
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        mem_gnt = 1'b1;
        mem_done = 1'b1;
        push_ret(1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0);
        mem_gnt = 1'b0;
        mem_done = 1'b0;
        idle_head();
        chk("count_after_restart", 72'(retire_count), 72'(exp_count));

        // Halt has priority over mispredict. After it, nothing retires.
        set_head(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, '0, 2'd0);
        push_ret(1'b1, 5'd4, 32'h44);
        step(1'b1, 1'b0, 1'b0);
        exp_halted = 1'b1;
        set_head(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h66, '0, 2'd0);
        step(1'b0, 1'b0, 1'b0);
        set_head(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h66, 32'h400, 2'd0);
        mem_gnt = 1'b1;
        mem_done = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        mem_gnt = 1'b0;
        mem_done = 1'b0;
        chk("count_after_halt", 72'(retire_count), 72'(exp_count));
        chk("retire_q_drained", 72'(exp_q.size()), 72'(0));
        chk("store_q_drained", 72'(st_q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
